// File: rtl/eth_phy_10g_tx_pcs_if.sv
// 10GBASE-R transmit PCS back end: selects scrambled, PRBS31 or square-wave
// blocks, optionally bit-reverses them and delays them through the SERDES pipeline.

module eth_phy_10g_tx_pcs_if #(
   parameter int DATA_WIDTH        = 64,
   parameter int HDR_WIDTH         = 2,
   parameter int BIT_REVERSE       = 0,
   parameter int SCRAMBLER_DISABLE = 0,
   parameter int PRBS31_ENABLE     = 0,
   parameter int SERDES_PIPELINE   = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_encoded_tx_data,
   input  logic [HDR_WIDTH-1:0]  i_encoded_tx_hdr,
   input  logic                  i_encoded_tx_hdr_valid,
   output logic [DATA_WIDTH-1:0] o_serdes_tx_data,
   output logic [HDR_WIDTH-1:0]  o_serdes_tx_hdr,
   output logic                  o_serdes_tx_hdr_valid,
   input  logic [1:0]            i_cfg_tx_test_mode
);

   typedef enum logic [1:0] {
      MODE_NORMAL   = 2'd0,
      MODE_PRBS31   = 2'd1,
      MODE_SQUARE   = 2'd2,
      MODE_RESERVED = 2'd3
   } testMode_t;

   localparam logic [63:0] SQUARE_PATTERN = 64'h00FF00FF00FF00FF;
   localparam int          STAGES         = SERDES_PIPELINE + 1;

   if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_badDataWidth
      $error("eth_phy_10g_tx_pcs_if: DATA_WIDTH must be 32 or 64");
   end
   if (HDR_WIDTH != 2) begin : g_badHdrWidth
      $error("eth_phy_10g_tx_pcs_if: HDR_WIDTH must be 2");
   end
   if (SERDES_PIPELINE < 0 || SERDES_PIPELINE > 4) begin : g_badPipeline
      $error("eth_phy_10g_tx_pcs_if: SERDES_PIPELINE must be 0 to 4");
   end

   logic [57:0]           r_scrState;
   logic [57:0]           w_scrWalk;
   logic [57:0]           w_scrNext;
   logic [30:0]           r_prbsState;
   logic [30:0]           w_prbsWalk;
   logic [30:0]           w_prbsNext;
   testMode_t             w_mode;
   logic                  w_isHdr;
   logic [DATA_WIDTH-1:0] w_scrData;
   logic [DATA_WIDTH-1:0] w_prbsData;
   logic [DATA_WIDTH-1:0] w_selData;
   logic [DATA_WIDTH-1:0] w_outData;
   logic [HDR_WIDTH-1:0]  w_prbsHdr;
   logic [HDR_WIDTH-1:0]  w_selHdr;
   logic [HDR_WIDTH-1:0]  w_outHdr;

   logic [DATA_WIDTH-1:0] r_pipeData [STAGES];
   logic [HDR_WIDTH-1:0]  r_pipeHdr  [STAGES];
   logic [STAGES-1:0]     r_pipeValid;

   // In 64-bit mode every word starts a block; reserved mode and a missing PRBS31 generator fall back to normal.
   always_comb begin
      w_isHdr = (DATA_WIDTH == 32) ? i_encoded_tx_hdr_valid : 1'b1;
      w_mode  = testMode_t'(i_cfg_tx_test_mode);
      if (w_mode == MODE_RESERVED || (w_mode == MODE_PRBS31 && PRBS31_ENABLE == 0)) begin
         w_mode = MODE_NORMAL;
      end
   end

   // Self-synchronous scrambler unrolled LSB-first; r_scrState[57] holds the newest scrambled bit.
   always_comb begin
      w_scrWalk = r_scrState;
      w_scrData = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         w_scrData[i] = i_encoded_tx_data[i] ^ w_scrWalk[19] ^ w_scrWalk[0];
         w_scrWalk    = {w_scrData[i], w_scrWalk[57:1]};
      end
   end

   // PRBS31 stream: header bits first on header cycles, then data, each the inverted feedback bit.
   always_comb begin
      w_prbsWalk = r_prbsState;
      w_prbsHdr  = '0;
      w_prbsData = '0;
      if (w_isHdr) begin
         for (int j = 0; j < HDR_WIDTH; j++) begin
            w_prbsWalk   = {w_prbsWalk[3] ^ w_prbsWalk[0], w_prbsWalk[30:1]};
            w_prbsHdr[j] = ~w_prbsWalk[30];
         end
      end
      for (int i = 0; i < DATA_WIDTH; i++) begin
         w_prbsWalk    = {w_prbsWalk[3] ^ w_prbsWalk[0], w_prbsWalk[30:1]};
         w_prbsData[i] = ~w_prbsWalk[30];
      end
   end

   // Pattern select; only the generator belonging to the active mode advances.
   always_comb begin
      w_selData  = i_encoded_tx_data;
      w_selHdr   = w_isHdr ? i_encoded_tx_hdr : '0;
      w_scrNext  = r_scrState;
      w_prbsNext = r_prbsState;
      case (w_mode)
         MODE_PRBS31: begin
            w_selData  = w_prbsData;
            w_selHdr   = w_prbsHdr;
            w_prbsNext = w_prbsWalk;
         end
         MODE_SQUARE: begin
            w_selData = SQUARE_PATTERN[DATA_WIDTH-1:0];
            w_selHdr  = w_isHdr ? {{(HDR_WIDTH-1){1'b0}}, 1'b1} : '0;
         end
         default: begin
            if (SCRAMBLER_DISABLE == 0) begin
               w_selData = w_scrData;
            end
            w_scrNext = w_scrWalk;
         end
      endcase
   end

   always_comb begin
      w_outData = w_selData;
      w_outHdr  = w_selHdr;
      if (BIT_REVERSE != 0) begin
         for (int i = 0; i < DATA_WIDTH; i++) begin
            w_outData[i] = w_selData[DATA_WIDTH-1-i];
         end
         for (int j = 0; j < HDR_WIDTH; j++) begin
            w_outHdr[j] = w_selHdr[HDR_WIDTH-1-j];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_scrState  <= '1;
         r_prbsState <= '1;
      end else begin
         r_scrState  <= w_scrNext;
         r_prbsState <= w_prbsNext;
      end
   end

   // Stage 0 is the mandatory output register; the rest are the optional SERDES stages.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < STAGES; k++) begin
            r_pipeData[k] <= '0;
            r_pipeHdr[k]  <= '0;
         end
         r_pipeValid <= '0;
      end else begin
         r_pipeData[0]  <= w_outData;
         r_pipeHdr[0]   <= w_outHdr;
         r_pipeValid[0] <= w_isHdr;
         for (int k = 1; k < STAGES; k++) begin
            r_pipeData[k]  <= r_pipeData[k-1];
            r_pipeHdr[k]   <= r_pipeHdr[k-1];
            r_pipeValid[k] <= r_pipeValid[k-1];
         end
      end
   end

   assign o_serdes_tx_data      = r_pipeData[STAGES-1];
   assign o_serdes_tx_hdr       = r_pipeHdr[STAGES-1];
   assign o_serdes_tx_hdr_valid = r_pipeValid[STAGES-1];

endmodule

// File: doc/eth_phy_10g_tx_pcs_if.md
# eth_phy_10g_tx_pcs_if

Parametrised 10GBASE-R transmit PCS back end. It takes 64b/66b-encoded blocks from the XGMII encoder and applies one of three transforms: self-synchronous scrambling, a PRBS31 test pattern, or a square-wave test pattern. It then applies optional bit reversal and a configurable pipeline before the SERDES. It supports 64-bit and 32-bit (half-block per cycle) SERDES widths and sits between `xgmii_baser_enc_64` and the transceiver.

## Interface
- DATA_WIDTH, 64: datapath width. Legal values are 32 and 64; any other value fails elaboration.
- HDR_WIDTH, 2: sync header width. Only 2 is legal.
- BIT_REVERSE, 0: 1 reverses bit order within the data word and within the header at the output.
- SCRAMBLER_DISABLE, 0: 1 passes data unscrambled in normal mode.
- PRBS31_ENABLE, 0: 0 removes the PRBS31 generator; test mode 1 then behaves as normal mode.
- SERDES_PIPELINE, 0: number of extra output register stages (0–4).

Ports:
- clk, in, 1: single clock; all logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- encoded_tx_data, in, DATA_WIDTH: block payload. In 32-bit mode this is the low half on the header cycle and the high half on the next cycle.
- encoded_tx_hdr, in, HDR_WIDTH: sync header. Sampled only when encoded_tx_hdr_valid=1.
- encoded_tx_hdr_valid, in, 1: marks the first half-block in 32-bit mode. Ignored in 64-bit mode, where every cycle is treated as a header cycle.
- serdes_tx_data, out, DATA_WIDTH: to SERDES.
- serdes_tx_hdr, out, HDR_WIDTH: to SERDES.
- serdes_tx_hdr_valid, out, 1: header qualifier for a gearbox-mode SERDES. Always 1 in 64-bit mode once out of reset.
- cfg_tx_test_mode, in, 2: selects the pattern. 0 is normal, 1 is PRBS31, 2 is square wave, 3 is reserved and treated as 0. Sampled every cycle.

## Operation
- Normal mode:
  - Data bits are scrambled LSB-first with G(x)=1+x^39+x^58: s_n = d_n ^ s_(n-39) ^ s_(n-58).
  - There is one 58-bit scrambler state, carried continuously across cycles and across the two halves in 32-bit mode.
  - The header is never scrambled.
  - The scrambler advances DATA_WIDTH bits per cycle in normal mode only, and holds its state in test modes.
  - With SCRAMBLER_DISABLE=1, data passes through unchanged and the scrambler state is still tracked.
- PRBS31 mode:
  - Uses the 1+x^28+x^31 LFSR; the output bit is the inverted LFSR output (802.3 49.2.8).
  - The header and data are both taken from the stream: header bits first (hdr[0] first), then data LSB-first.
  - The LFSR advances HDR_WIDTH+DATA_WIDTH bits on header cycles and DATA_WIDTH bits on 32-bit non-header cycles.
  - It holds its state outside PRBS31 mode.
- Square-wave mode:
  - serdes_tx_hdr = 2'b01 on header cycles.
  - Data is a repeating pattern of 8 ones followed by 8 zeros, LSB-first: 64'h00FF00FF00FF00FF, or 32'h00FF00FF in 32-bit mode.
- Header qualifier: serdes_tx_hdr_valid equals the pipelined encoded_tx_hdr_valid in 32-bit mode, and 1 in 64-bit mode. On 32-bit non-header cycles, serdes_tx_hdr is 2'b00.
- Bit reversal: applied after pattern selection, when BIT_REVERSE=1.
- Reset state:
  - Scrambler state is all ones; PRBS31 state is all ones.
  - serdes_tx_data, serdes_tx_hdr and serdes_tx_hdr_valid are 0, and every pipeline stage is cleared.
- Mode change: takes effect for the next input word. There is no flush. Each generator resumes from its held state.
- Reset mid-operation: everything returns to the reset state on the next edge. In-flight pipeline data is discarded.
- 32-bit protocol: upstream guarantees that header cycles alternate with non-header cycles. The block does not check this and simply propagates the qualifier.

## Timing
- Input-to-output latency is 1 + SERDES_PIPELINE cycles, identical for all modes and widths.
- Data, header and header-valid stay aligned through every stage.
- After rst is deasserted, outputs hold their reset values until the first registered input emerges, 1 + SERDES_PIPELINE edges later.
- No backpressure: one word is accepted every cycle.

## Test plan
- **Reset.** Hold rst for 4 cycles with random inputs, SERDES_PIPELINE=2. Required: all outputs 0 during reset and for 3 cycles after release.
- **Pass-through.** SCRAMBLER_DISABLE=1, 64-bit, data 64'h0123456789ABCDEF, hdr 2'b01. Required: the same word and hdr 2'b01 appear 1 cycle later, with hdr_valid=1.
- **Scrambler seed.** Normal mode immediately after reset, 64-bit, data 0, hdr 2'b10. Required: first output data 64'h03FFFF8000000000 and hdr 2'b10. Subsequent words match a bit-serial reference model over 1000 cycles.
- **PRBS31.** PRBS31_ENABLE=1, mode 1, 64-bit. Required: the 66-bit concatenated stream (hdr then data) locks a reference PRBS31 checker with 0 errors over 1000 cycles. Switching to mode 0 and back resumes the sequence without error.
- **Square wave.** Mode 2, 64-bit. Required: data 64'h00FF00FF00FF00FF and hdr 2'b01 on every cycle.
- **32-bit combined.** DATA_WIDTH=32, BIT_REVERSE=1, SERDES_PIPELINE=2, alternating hdr_valid, hdr 2'b01, halves 32'h00000001 / 32'h80000000, scrambler disabled. Required:
  - Latency is 3.
  - serdes_tx_hdr is 2'b10 with hdr_valid 1 on the first half, and 2'b00 with hdr_valid 0 on the second half.
  - Data is 32'h80000000 then 32'h00000001.
